// File: rtl/serial_image_loader.sv
// -----------------------------------------------------------------------------
// serial_image_loader
//
// Sits upstream of the morphologic GA. It parses the byte stream from the
// serial receiver into framed commands:
//   A5 01 <N bytes> <csum>  load origin image
//   A5 02 <N bytes> <csum>  load objective image
//   A5 03                   start: pulse ga_rst (only once both images exist)
// with N = ImageWidth*ImageHeight/8 and csum = cmd XOR all payload bytes.
// Payload bytes collect in a shadow register. The visible image only changes
// when a frame passes its checksum, so the GA never sees a partial image.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   rx_data    received byte
//   rx_valid   one-cycle strobe qualifying rx_data
//   origin     committed origin image (first payload byte in the MSBs)
//   objective  committed objective image (same byte order)
//   ga_rst     reset to the GA core, high for GaRstCycles cycles
//   ready      both images committed at least once since reset
//   busy       frame parser not idle
//   frame_ok   one-cycle pulse: load frame committed
//   frame_err  one-cycle pulse: frame rejected
//
// Build option:
//   DEFAULT_IMAGES_EN  when defined, reset loads a built-in origin/objective
//                      pair and marks both images as loaded (ready=1 out of
//                      reset). The pair is meant for 8x4. Other sizes take it
//                      zero-extended or truncated.
// -----------------------------------------------------------------------------
module serial_image_loader #(
  parameter int ImageWidth    = 8,
  parameter int ImageHeight   = 4,
  parameter int TimeoutCycles = 1000,
  parameter int GaRstCycles   = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [7:0]                          rx_data,
  input  logic                                rx_valid,
  output logic [ImageWidth*ImageHeight-1:0]   origin,
  output logic [ImageWidth*ImageHeight-1:0]   objective,
  output logic                                ga_rst,
  output logic                                ready,
  output logic                                busy,
  output logic                                frame_ok,
  output logic                                frame_err
);

  localparam int Img    = ImageWidth * ImageHeight;
  localparam int NBytes = Img / 8;
  localparam int TW     = $clog2(TimeoutCycles + 1);
  localparam int GW     = $clog2(GaRstCycles + 1);
  localparam int BW     = $clog2(NBytes + 1);

  localparam logic [7:0] SYNC          = 8'hA5;
  localparam logic [7:0] CMD_ORIGIN    = 8'h01;
  localparam logic [7:0] CMD_OBJECTIVE = 8'h02;
  localparam logic [7:0] CMD_START     = 8'h03;

`ifdef DEFAULT_IMAGES_EN
  localparam logic [Img-1:0] ORIGIN_RST    = Img'(32'h00100000);
  localparam logic [Img-1:0] OBJECTIVE_RST = Img'(32'h387C3810);
  localparam logic           LOADED_RST    = 1'b1;
`else
  localparam logic [Img-1:0] ORIGIN_RST    = '0;
  localparam logic [Img-1:0] OBJECTIVE_RST = '0;
  localparam logic           LOADED_RST    = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_PAYLOAD,
    S_CHECK,
    S_START
  } state_t;

  state_t           state, state_nx;
  logic [TW-1:0]    idle_cnt;
  logic [BW-1:0]    byte_cnt;
  logic [GW-1:0]    ga_cnt;
  logic             target_obj;
  logic             origin_loaded, objective_loaded;
  logic [Img-1:0]   shadow;
  logic [7:0]       acc;

  logic             ok_nx, err_nx;
  logic             start_frame, shift_en, commit;
  logic             pulse_start, pulse_end;
  logic             in_frame, timed_out;

  assign ready = origin_loaded & objective_loaded;

  // The idle counter only runs while a frame is open. A byte arriving on
  // the expiry cycle takes priority over the timeout.
  assign in_frame  = (state == S_CMD) || (state == S_PAYLOAD) || (state == S_CHECK);
  assign timed_out = in_frame && !rx_valid && (idle_cnt == TW'(TimeoutCycles - 1));

  always_comb begin
    state_nx    = state;
    ok_nx       = 1'b0;
    err_nx      = 1'b0;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    commit      = 1'b0;
    pulse_start = 1'b0;
    pulse_end   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC)) state_nx = S_CMD;
      end
      S_CMD: begin
        if (rx_valid) begin
          if ((rx_data == CMD_ORIGIN) || (rx_data == CMD_OBJECTIVE)) begin
            state_nx    = S_PAYLOAD;
            start_frame = 1'b1;
          end else if ((rx_data == CMD_START) && ready) begin
            state_nx    = S_START;
            pulse_start = 1'b1;
          end else begin
            state_nx = S_IDLE;
            err_nx   = 1'b1;
          end
        end else if (timed_out) begin
          state_nx = S_IDLE;
          err_nx   = 1'b1;
        end
      end
      S_PAYLOAD: begin
        // 0xA5 here is payload data, never a resync.
        if (rx_valid) begin
          shift_en = 1'b1;
          if (byte_cnt == BW'(NBytes - 1)) state_nx = S_CHECK;
        end else if (timed_out) begin
          state_nx = S_IDLE;
          err_nx   = 1'b1;
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          state_nx = S_IDLE;
          if (rx_data == acc) begin
            commit = 1'b1;
            ok_nx  = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end else if (timed_out) begin
          state_nx = S_IDLE;
          err_nx   = 1'b1;
        end
      end
      S_START: begin
        // Incoming bytes are dropped for the whole pulse.
        if (ga_cnt == GW'(GaRstCycles - 1)) begin
          state_nx  = S_IDLE;
          pulse_end = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      frame_ok         <= 1'b0;
      frame_err        <= 1'b0;
      ga_rst           <= 1'b0;
      idle_cnt         <= '0;
      byte_cnt         <= '0;
      ga_cnt           <= '0;
      target_obj       <= 1'b0;
      origin           <= ORIGIN_RST;
      objective        <= OBJECTIVE_RST;
      origin_loaded    <= LOADED_RST;
      objective_loaded <= LOADED_RST;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != S_IDLE);
      frame_ok  <= ok_nx;
      frame_err <= err_nx;

      if (rx_valid || (state_nx == S_IDLE) || (state_nx == S_START))
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;

      if (start_frame) begin
        byte_cnt   <= '0;
        target_obj <= (rx_data == CMD_OBJECTIVE);
      end else if (shift_en) begin
        byte_cnt <= byte_cnt + 1'b1;
      end

      if (pulse_start) begin
        ga_rst <= 1'b1;
        ga_cnt <= '0;
      end else if (pulse_end) begin
        ga_rst <= 1'b0;
      end else if (state == S_START) begin
        ga_cnt <= ga_cnt + 1'b1;
      end

      // Commit the shadow image to the selected output.
      if (commit) begin
        if (target_obj) begin
          objective        <= shadow;
          objective_loaded <= 1'b1;
        end else begin
          origin        <= shadow;
          origin_loaded <= 1'b1;
        end
      end
    end
  end

  // Shadow image and running checksum. Each frame fully rewrites them
  // before they are used, so they need no reset.
  always_ff @(posedge clk) begin
    if (start_frame) begin
      acc <= rx_data;
    end else if (shift_en) begin
      acc    <= acc ^ rx_data;
      shadow <= (shadow << 8) | Img'(rx_data);
    end
  end

endmodule

// File: tb/tb_serial_image_loader.sv
module tb_serial_image_loader;

  localparam int W      = 8;
  localparam int H      = 4;
  localparam int IMG    = W * H;
  localparam int NB     = IMG / 8;
  localparam int TO_CYC = 1000;
  localparam int GA_CYC = 4;

`ifdef DEFAULT_IMAGES_EN
  localparam logic [IMG-1:0] ORG_RST = 32'h00100000;
  localparam logic [IMG-1:0] OBJ_RST = 32'h387C3810;
  localparam bit             LD_RST  = 1'b1;
`else
  localparam logic [IMG-1:0] ORG_RST = '0;
  localparam logic [IMG-1:0] OBJ_RST = '0;
  localparam bit             LD_RST  = 1'b0;
`endif

  logic           clk, rst;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic [IMG-1:0] origin, objective;
  logic           ga_rst, ready, busy, frame_ok, frame_err;

  serial_image_loader #(
    .ImageWidth(W), .ImageHeight(H), .TimeoutCycles(TO_CYC), .GaRstCycles(GA_CYC)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .origin(origin), .objective(objective), .ga_rst(ga_rst), .ready(ready),
    .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit             ok;
    logic [IMG-1:0] org;
    logic [IMG-1:0] obj;
    bit             rdy;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int failures = 0;

  // Reference model: committed images and loaded flags.
  logic [IMG-1:0] m_org, m_obj;
  bit m_org_ld, m_obj_ld;
  int exp_pulses = 0;
  int pulses = 0;
  int hcnt = 0;

  task automatic check(input string name, input logic [IMG-1:0] act, input logic [IMG-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_org = ORG_RST; m_obj = OBJ_RST;
    m_org_ld = LD_RST; m_obj_ld = LD_RST;
  endtask

  // Scoreboard monitor: pops one expectation per frame_ok/frame_err pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_ok && frame_err) check("ok_err_exclusive", 1, 0);
      if (frame_ok || frame_err) begin
        if (expq.size() == 0) begin
          check("unexpected_frame_event", {frame_ok, frame_err}, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("frame_ok", frame_ok, e.ok);
          check("frame_err", frame_err, !e.ok);
          check("origin", origin, e.org);
          check("objective", objective, e.obj);
          check("ready", ready, e.rdy);
          check("busy_after_frame", busy, 0);
        end
      end
    end
  end

  // ga_rst monitor: measures each pulse and checks busy stays high with it.
  always @(negedge clk) begin
    if (rst) begin
      hcnt = 0;
    end else if (ga_rst) begin
      hcnt++;
      if (!busy) check("busy_during_ga_rst", busy, 1);
    end else if (hcnt != 0) begin
      check("ga_rst_len", hcnt, GA_CYC);
      pulses++;
      hcnt = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_exp(input bit ok);
    exp_t e;
    e.ok = ok; e.org = m_org; e.obj = m_obj; e.rdy = m_org_ld && m_obj_ld;
    expq.push_back(e);
  endtask

  // Full load frame; a nonzero badmask corrupts the checksum.
  task automatic load_frame(input logic [7:0] cmd, input logic [IMG-1:0] img,
                            input logic [7:0] badmask, input int maxgap);
    logic [7:0] cs;
    cs = cmd;
    for (int i = 0; i < NB; i++) cs = cs ^ img[IMG-1-8*i -: 8];
    cs = cs ^ badmask;
    if (badmask == 8'h00) begin
      if (cmd == 8'h01) begin m_org = img; m_org_ld = 1; end
      else begin m_obj = img; m_obj_ld = 1; end
      push_exp(1);
    end else begin
      push_exp(0);
    end
    send_byte(8'hA5); idle($urandom_range(0, maxgap));
    send_byte(cmd);   idle($urandom_range(0, maxgap));
    for (int i = 0; i < NB; i++) begin
      send_byte(img[IMG-1-8*i -: 8]);
      idle($urandom_range(0, maxgap));
    end
    send_byte(cs);
    idle(2);
  endtask

  task automatic start_cmd(input bit mid_bytes);
    if (m_org_ld && m_obj_ld) exp_pulses++;
    else push_exp(0);
    send_byte(8'hA5);
    send_byte(8'h03);
    if (mid_bytes) begin
      send_byte(8'hA5);
      send_byte(8'h01);
    end
    idle(GA_CYC + 3);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk); #1;
    check("rst_origin", origin, ORG_RST);
    check("rst_objective", objective, OBJ_RST);
    check("rst_ready", ready, LD_RST);
    check("rst_busy", busy, 0);
    check("rst_ga_rst", ga_rst, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_frame_err", frame_err, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Start before both images exist.
    start_cmd(0);
    check("ga_rst_pulses_early", pulses, exp_pulses);

    // Garbage in IDLE is ignored.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h03);
    idle(3);
    check("idle_after_garbage", busy, 0);

    // Directed test vectors.
    load_frame(8'h01, 32'h00100000, 8'h00, 0);
    load_frame(8'h02, 32'h387C3810, 8'h00, 0);
    load_frame(8'h02, 32'h387C3810, 8'h01, 0);

    start_cmd(1);
    check("ga_rst_pulses_start", pulses, exp_pulses);

    push_exp(0);
    send_byte(8'hA5); send_byte(8'h07);
    idle(2);

    // Timeout: exactly TO_CYC idle cycles after a byte aborts the frame.
    push_exp(0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
    idle(TO_CYC);
    idle(2);
    check("idle_after_timeout", busy, 0);

    // A byte on the last allowed idle cycle keeps the frame alive.
    m_org = 32'h00100000; m_org_ld = 1;
    push_exp(1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
    idle(TO_CYC - 1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h11);
    idle(2);

    // Reset in the middle of a payload.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("midrst_origin", origin, ORG_RST);
    check("midrst_objective", objective, OBJ_RST);
    check("midrst_ready", ready, LD_RST);
    check("midrst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    load_frame(8'h01, 32'hDEADBEEF, 8'h00, 1);
    load_frame(8'h02, 32'hA5A5A5A5, 8'h00, 1);

    // Randomized frames.
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 6) begin
        logic [7:0] mask;
        logic [7:0] cmd;
        cmd  = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
        mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        load_frame(cmd, IMG'($urandom), mask, 3);
      end else if (kind == 7) begin
        push_exp(0);
        send_byte(8'hA5);
        send_byte(8'($urandom_range(4, 255)));
        idle(2);
      end else if (kind == 8) begin
        start_cmd(1);
      end else begin
        for (int g = 0; g < 3; g++) begin
          logic [7:0] b;
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h00;
          send_byte(b);
        end
        idle(1);
      end
    end

    idle(10);
    check("scoreboard_drained", expq.size(), 0);
    check("ga_rst_pulses_total", pulses, exp_pulses);
    check("final_origin", origin, m_org);
    check("final_objective", objective, m_obj);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
